// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control and RNE rounding.
// Optional sticky exception accumulator enabled by defining FP_MUL_PIPE_STICKY_FLAGS_EN.
module fp_mul_pipe #(
  parameter  int EXP_WIDTH  = 8,
  parameter  int FRAC_WIDTH = 7,
  localparam int W          = 1 + EXP_WIDTH + FRAC_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_res,
  output logic [3:0]   out_flags
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
  ,
  input  logic         flags_clr,
  output logic [3:0]   sticky_flags
`endif
);

  localparam int M  = FRAC_WIDTH + 1;
  localparam int PW = 2 * M;
  localparam int EW = EXP_WIDTH + 2;

  localparam logic [EW-1:0]        BIAS_V    = EW'((2 ** (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((2 ** EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO  = {EW{1'b0}};
  localparam logic [EXP_WIDTH-1:0] EXP_ONES  = {EXP_WIDTH{1'b1}};
  localparam logic [EXP_WIDTH-1:0] EXP_NONE  = {EXP_WIDTH{1'b0}};
  localparam logic [FRAC_WIDTH-1:0] FRAC_NONE = {FRAC_WIDTH{1'b0}};
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(FRAC_WIDTH-1){1'b0}}};

  // Handshake chain
  logic w_adv1, w_adv2, w_adv3;

  // Stage 1 combinational decode
  logic [EXP_WIDTH-1:0]  w_exp_a, w_exp_b;
  logic [FRAC_WIDTH-1:0] w_frac_a, w_frac_b;
  logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic w_s1_inv, w_s1_nan, w_s1_inf, w_s1_zero;
  logic signed [EW-1:0] w_exp_sum;

  // Stage 1 registers
  logic                 r1_valid, r1_sign, r1_nan, r1_inv, r1_inf, r1_zero;
  logic signed [EW-1:0] r1_exp;
  logic [M-1:0]         r1_ma, r1_mb;

  // Stage 2 registers
  logic                 r2_valid, r2_sign, r2_nan, r2_inv, r2_inf, r2_zero;
  logic signed [EW-1:0] r2_exp;
  logic [PW-1:0]        r2_prod;

  // Stage 3 combinational normalise/round/pack
  logic                  w_norm, w_guard, w_sticky, w_round_up, w_rcarry, w_ovf, w_unf;
  logic [M-1:0]          w_kept;
  logic [M:0]            w_rounded;
  logic [FRAC_WIDTH-1:0] w_frac;
  logic signed [EW-1:0]  w_exp_fin;
  logic [W-1:0]          w_res;
  logic [3:0]            w_flags;

  // Stage 3 / output registers
  logic         r3_valid;
  logic [W-1:0] r_out_res;
  logic [3:0]   r_out_flags;

  // Each stage may move when the stage after it is empty or moving
  always_comb begin
    w_adv3 = !r3_valid || out_ready;
    w_adv2 = !r2_valid || w_adv3;
    w_adv1 = !r1_valid || w_adv2;
  end

  assign in_ready  = w_adv1;
  assign out_valid = r3_valid;
  assign out_res   = r_out_res;
  assign out_flags = r_out_flags;

  // Operand unpack and classification; subnormals are treated as zero
  always_comb begin
    w_exp_a   = op_a[W-2 -: EXP_WIDTH];
    w_exp_b   = op_b[W-2 -: EXP_WIDTH];
    w_frac_a  = op_a[FRAC_WIDTH-1:0];
    w_frac_b  = op_b[FRAC_WIDTH-1:0];
    w_a_zero  = (w_exp_a == EXP_NONE);
    w_b_zero  = (w_exp_b == EXP_NONE);
    w_a_inf   = (w_exp_a == EXP_ONES) && (w_frac_a == FRAC_NONE);
    w_b_inf   = (w_exp_b == EXP_ONES) && (w_frac_b == FRAC_NONE);
    w_a_nan   = (w_exp_a == EXP_ONES) && (w_frac_a != FRAC_NONE);
    w_b_nan   = (w_exp_b == EXP_ONES) && (w_frac_b != FRAC_NONE);
    w_s1_inv  = (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    w_s1_nan  = w_a_nan || w_b_nan || w_s1_inv;
    w_s1_inf  = w_a_inf || w_b_inf;
    w_s1_zero = w_a_zero || w_b_zero;
    w_exp_sum = {2'b00, w_exp_a} + {2'b00, w_exp_b} - BIAS_V;
  end

  // Stage 1 register: class bits, sign, biased exponent sum, mantissas
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_nan   <= 1'b0;
      r1_inv   <= 1'b0;
      r1_inf   <= 1'b0;
      r1_zero  <= 1'b0;
      r1_exp   <= EXP_ZERO;
      r1_ma    <= {M{1'b0}};
      r1_mb    <= {M{1'b0}};
    end else if (w_adv1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign <= op_a[W-1] ^ op_b[W-1];
        r1_nan  <= w_s1_nan;
        r1_inv  <= w_s1_inv;
        r1_inf  <= w_s1_inf;
        r1_zero <= w_s1_zero;
        r1_exp  <= w_exp_sum;
        r1_ma   <= {1'b1, w_frac_a};
        r1_mb   <= {1'b1, w_frac_b};
      end
    end
  end

  // Stage 2 register: full-width mantissa product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_nan   <= 1'b0;
      r2_inv   <= 1'b0;
      r2_inf   <= 1'b0;
      r2_zero  <= 1'b0;
      r2_exp   <= EXP_ZERO;
      r2_prod  <= {PW{1'b0}};
    end else if (w_adv2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign <= r1_sign;
        r2_nan  <= r1_nan;
        r2_inv  <= r1_inv;
        r2_inf  <= r1_inf;
        r2_zero <= r1_zero;
        r2_exp  <= r1_exp;
        r2_prod <= r1_ma * r1_mb;
      end
    end
  end

  // Normalise, round to nearest even, range check and special-case select
  always_comb begin
    w_norm = r2_prod[PW-1];
    if (w_norm) begin
      w_kept   = r2_prod[PW-1 -: M];
      w_guard  = r2_prod[M-1];
      w_sticky = |r2_prod[M-2:0];
    end else begin
      w_kept   = r2_prod[PW-2 -: M];
      w_guard  = r2_prod[M-2];
      w_sticky = |r2_prod[M-3:0];
    end
    w_round_up = w_guard && (w_sticky || w_kept[0]);
    w_rounded  = {1'b0, w_kept} + {{M{1'b0}}, w_round_up};
    w_rcarry   = w_rounded[M];
    // A carry out leaves 1.000..0, so the fraction is the shifted-down low bits
    if (w_rcarry) begin
      w_frac = w_rounded[FRAC_WIDTH:1];
    end else begin
      w_frac = w_rounded[FRAC_WIDTH-1:0];
    end
    w_exp_fin = r2_exp + {{(EW-1){1'b0}}, w_norm} + {{(EW-1){1'b0}}, w_rcarry};
    w_ovf     = (w_exp_fin >= EXP_MAX_S);
    w_unf     = (w_exp_fin <= EXP_ZERO);

    if (r2_nan) begin
      w_res   = QNAN;
      w_flags = {r2_inv, 3'b000};
    end else if (r2_inf) begin
      w_res   = {r2_sign, EXP_ONES, FRAC_NONE};
      w_flags = 4'b0000;
    end else if (r2_zero) begin
      w_res   = {r2_sign, EXP_NONE, FRAC_NONE};
      w_flags = 4'b0000;
    end else if (w_ovf) begin
      w_res   = {r2_sign, EXP_ONES, FRAC_NONE};
      w_flags = 4'b0101;
    end else if (w_unf) begin
      w_res   = {r2_sign, EXP_NONE, FRAC_NONE};
      w_flags = 4'b0011;
    end else begin
      w_res   = {r2_sign, w_exp_fin[EXP_WIDTH-1:0], w_frac};
      w_flags = {3'b000, w_guard || w_sticky};
    end
  end

  // Stage 3 register: packed result and flags, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_valid    <= 1'b0;
      r_out_res   <= {W{1'b0}};
      r_out_flags <= 4'b0000;
    end else if (w_adv3) begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r_out_res   <= w_res;
        r_out_flags <= w_flags;
      end
    end
  end

`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
  logic       w_out_hs;
  logic [3:0] r_sticky_flags;

  assign w_out_hs     = r3_valid && out_ready;
  assign sticky_flags = r_sticky_flags;

  // Accumulate flags of delivered results; a clear concurrent with delivery keeps only the new flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky_flags <= 4'b0000;
    end else if (w_out_hs) begin
      r_sticky_flags <= flags_clr ? r_out_flags : (r_sticky_flags | r_out_flags);
    end else if (flags_clr) begin
      r_sticky_flags <= 4'b0000;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed-vector bench for fp_mul_pipe (bfloat16 configuration): table of products,
// backpressure streaming and mid-stream reset sequences.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_res;
  logic [3:0]  out_flags;
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
  logic        flags_clr;
  logic [3:0]  sticky_flags;
`endif

  fp_mul_pipe #(.EXP_WIDTH(8), .FRAC_WIDTH(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
    ,
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];
  logic [15:0] sb [6];

  int n_checks = 0;
  int n_fail   = 0;

  int sent, got, cyc, first_seen, stale, extra;
  logic held_prev, saw_block;
  logic [15:0] prev_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated operation with out_ready high; returns at the negedge where the result is valid
  task automatic apply(input int i);
    int lat;
    @(negedge clk);
    op_a     = vecs[i].a;
    op_b     = vecs[i].b;
    in_valid = 1'b1;
    check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
    check($sformatf("v%0d latency", i), lat, 32'd3);
    check($sformatf("v%0d res", i), {16'd0, out_res}, {16'd0, vecs[i].res});
    check($sformatf("v%0d flags", i), {28'd0, out_flags}, {28'd0, vecs[i].flags});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{16'h3FC0, 16'h3FC0, 16'h4010, 4'b0000};
    vecs[1]  = '{16'h4040, 16'h4040, 16'h4110, 4'b0000};
    vecs[2]  = '{16'h3F81, 16'h3F81, 16'h3F82, 4'b0001};
    vecs[3]  = '{16'h3F81, 16'h3FC0, 16'h3FC2, 4'b0001};
    vecs[4]  = '{16'h7F00, 16'h4000, 16'h7F80, 4'b0101};
    vecs[5]  = '{16'h0080, 16'h3F00, 16'h0000, 4'b0011};
    vecs[6]  = '{16'h7F80, 16'h0000, 16'h7FC0, 4'b1000};
    vecs[7]  = '{16'hFF80, 16'h3F80, 16'hFF80, 4'b0000};
    vecs[8]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 4'b0000};
    vecs[9]  = '{16'h8000, 16'h4000, 16'h8000, 4'b0000};
    vecs[10] = '{16'h3FB5, 16'h3FB5, 16'h4000, 4'b0001};
    vecs[11] = '{16'hBFC0, 16'h3FC0, 16'hC010, 4'b0000};
    vecs[12] = '{16'h7F00, 16'h3F80, 16'h7F00, 4'b0000};
    vecs[13] = '{16'h0080, 16'h3F80, 16'h0080, 4'b0000};
    vecs[14] = '{16'h0001, 16'h3F80, 16'h0000, 4'b0000};
    vecs[15] = '{16'h0000, 16'h7F80, 16'h7FC0, 4'b1000};
    sb[0] = 16'h4000; sb[1] = 16'h4040; sb[2] = 16'h4080;
    sb[3] = 16'h40A0; sb[4] = 16'h40C0; sb[5] = 16'h40E0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = 16'h0000;
    op_b      = 16'h0000;
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_res", {16'd0, out_res}, 32'd0);
    check("reset out_flags", {28'd0, out_flags}, 32'd0);
`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
    check("reset sticky", {28'd0, sticky_flags}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) apply(i);

`ifdef FP_MUL_PIPE_STICKY_FLAGS_EN
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    check("sticky cleared", {28'd0, sticky_flags}, 32'd0);
    apply(4);
    apply(2);
    check("sticky accumulate", {28'd0, sticky_flags}, 32'h5);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    check("sticky clr with handshake", {28'd0, sticky_flags}, 32'h1);
`endif

    // Backpressure: six back-to-back products, consumer stalls 4 cycles after first result
    @(negedge clk);
    sent = 0; got = 0; cyc = 0; first_seen = -1;
    held_prev = 1'b0; saw_block = 1'b0; prev_res = 16'h0000;
    while (got < 6 && cyc < 100) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid && first_seen < 0) first_seen = cyc;
      out_ready = !(first_seen >= 0 && cyc < first_seen + 4);
      in_valid  = (sent < 6);
      op_a      = 16'h3F80;
      op_b      = (sent < 6) ? sb[sent] : 16'h0000;
      #1;
      if (held_prev) begin
        check("bp held valid", {31'd0, out_valid}, 32'd1);
        check("bp held res", {16'd0, out_res}, {16'd0, prev_res});
      end
      if (!in_ready && !saw_block) begin
        saw_block = 1'b1;
        check("bp occupancy at block", sent - got, 32'd3);
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp res %0d", got), {16'd0, out_res}, {16'd0, sb[got]});
        check($sformatf("bp flags %0d", got), {28'd0, out_flags}, 32'd0);
        got++;
      end
      held_prev = out_valid && !out_ready;
      prev_res  = out_res;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp results received", got, 32'd6);
    check("bp operations sent", sent, 32'd6);
    check("bp in_ready dropped", {31'd0, saw_block}, 32'd1);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("bp no duplicates", extra, 32'd0);

    // Mid-stream reset with operations in flight and a result held
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op_a     = 16'h3FC0;
      op_b     = sb[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async reset out_valid", {31'd0, out_valid}, 32'd0);
    check("async reset out_res", {16'd0, out_res}, 32'd0);
    check("async reset out_flags", {28'd0, out_flags}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("in_ready after mid reset", {31'd0, in_ready}, 32'd1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no stale results", stale, 32'd0);
    apply(0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
